// File: rtl/frame_compositor.sv
// frame_compositor: picks one of NUM_IMAGES 1-bpp ROM rows per pixel, commits image changes only at
// frame start (optionally as a left-to-right wipe) and drives registered r/g/b. Macro BLINK_EN adds a blink input.
module frame_compositor #(
  parameter int          WIDTH        = 640,
  parameter int          HEIGHT       = 480,
  parameter int          NUM_IMAGES   = 8,
  parameter int          DEFAULT_IMG  = 4,
  parameter int          WIPE_STEP    = 80,
  parameter logic [23:0] FG_RGB       = 24'hBF40BF,
  parameter logic [23:0] BG_RGB       = 24'hFFD700,
  parameter logic [23:0] CLR_RGB      = 24'hBF40BF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [$clog2(WIDTH)-1:0]      x,
  input  logic [$clog2(HEIGHT)-1:0]     y,
  input  logic [$clog2(NUM_IMAGES)-1:0] sel,
  input  logic                          clear,
`ifdef BLINK_EN
  input  logic                          blink,
`endif
  input  logic [NUM_IMAGES*WIDTH-1:0]   row_data,
  output logic [$clog2(HEIGHT)-1:0]     rom_addr,
  output logic [7:0]                    r,
  output logic [7:0]                    g,
  output logic [7:0]                    b,
  output logic [$clog2(NUM_IMAGES)-1:0] cur_img,
  output logic                          busy,
  output logic                          frame_tick
);

  localparam int XW = $clog2(WIDTH);
  localparam int IW = $clog2(NUM_IMAGES);
  localparam int CW = XW + 1;
  localparam int PW = $clog2(NUM_IMAGES * WIDTH);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW:0]   WIDTH_X = (CW+1)'(WIDTH);
  localparam logic [CW:0]   STEP_C  = (CW+1)'(WIPE_STEP);
  localparam logic [IW:0]   NUM_C   = (IW+1)'(NUM_IMAGES);
  localparam logic [IW-1:0] DEF_C   = IW'(DEFAULT_IMG);

  if (BLINK_FRAMES < 1 || DEFAULT_IMG >= NUM_IMAGES || WIPE_STEP < 0) begin : g_bad_params
    $error("frame_compositor: illegal parameter combination");
  end

  typedef enum logic {IDLE, WIPE} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   old_img;
  logic [CW-1:0]   wipe_col;
  logic            origin_q;

  logic            at_origin, frame_start;
  logic [IW-1:0]   sel_s;
  logic [CW:0]     wipe_sum;
  logic [IW-1:0]   eff_cur, eff_old;
  logic [CW-1:0]   eff_wipe;
  logic            eff_busy;

  logic            valid_d, clear_d, busy_d;
  logic [XW-1:0]   x_d;
  logic [IW-1:0]   cur_d, old_d;
  logic [CW-1:0]   wipe_d;

  logic [IW-1:0]   show_img;
  logic [PW-1:0]   pix_idx;
  logic            blank;
  logic [23:0]     rgb_n;

  assign rom_addr    = y;
  assign at_origin   = (x == '0) && (y == '0);
  assign frame_start = at_origin && !origin_q;
  assign sel_s       = ({1'b0, sel} >= NUM_C) ? DEF_C : sel;
  assign wipe_sum    = {1'b0, wipe_col} + STEP_C;

  // State the frame will run with: identical to the registers except on the frame-start cycle.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a latch behind.
    next_state = state;
    eff_cur    = cur_img;
    eff_old    = old_img;
    eff_wipe   = wipe_col;
    eff_busy   = busy;
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (sel_s != cur_img) begin
            eff_cur = sel_s;
            if (WIPE_STEP != 0) begin
              eff_old    = cur_img;
              eff_wipe   = '0;
              eff_busy   = 1'b1;
              next_state = WIPE;
            end
          end
        end
        WIPE: begin
          if (wipe_sum >= WIDTH_X) begin
            eff_wipe   = WIDTH_C;
            eff_busy   = 1'b0;
            next_state = IDLE;
          end else begin
            eff_wipe = wipe_sum[CW-1:0];
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      cur_img    <= DEF_C;
      old_img    <= DEF_C;
      wipe_col   <= WIDTH_C;
      busy       <= 1'b0;
      origin_q   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= next_state;
      cur_img    <= eff_cur;
      old_img    <= eff_old;
      wipe_col   <= eff_wipe;
      busy       <= eff_busy;
      origin_q   <= at_origin;
      frame_tick <= frame_start;
    end
  end

  // Stage 1 runs alongside the ROM read; it captures the post-commit state so pixel (0,0)
  // already belongs to the newly committed frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: pipeline registers are reset too; valid_d keeps r/g/b at 0 until real data arrives.
    if (reset) begin
      valid_d <= 1'b0;
      x_d     <= '0;
      clear_d <= 1'b0;
      busy_d  <= 1'b0;
      cur_d   <= '0;
      old_d   <= '0;
      wipe_d  <= '0;
    end else begin
      valid_d <= 1'b1;
      x_d     <= x;
      clear_d <= clear;
      busy_d  <= eff_busy;
      cur_d   <= eff_cur;
      old_d   <= eff_old;
      wipe_d  <= eff_wipe;
    end
  end

`ifdef BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase, blink_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_d     <= 1'b0;
    end else begin
      blink_d <= blink;
      if (!blink) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (frame_start) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign blank = blink_d && blink_phase;
`else
  assign blank = 1'b0;
`endif

  // Stage 2: columns at or right of the wipe edge still show the outgoing image.
  assign show_img = (busy_d && ({1'b0, x_d} >= wipe_d)) ? old_d : cur_d;
  assign pix_idx  = PW'(show_img) * PW'(WIDTH) + PW'(WIDTH - 1) - PW'(x_d);

  always_comb begin
    rgb_n = 24'h000000;
    if (valid_d) begin
      if (clear_d)            rgb_n = CLR_RGB;
      else if (blank)         rgb_n = BG_RGB;
      else if (row_data[pix_idx]) rgb_n = FG_RGB;
      else                    rgb_n = BG_RGB;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r <= 8'h00;
      g <= 8'h00;
      b <= 8'h00;
    end else begin
      r <= rgb_n[23:16];
      g <= rgb_n[15:8];
      b <= rgb_n[7:0];
    end
  end

endmodule

// File: tb/tb_frame_compositor.sv
// Bench for frame_compositor: a frame-level model drives per-cycle comparison of two instances
// (instant switch and 4-column wipe), plus literal expectations at key pixels.
module tb_frame_compositor;

  localparam int W = 16;
  localparam int H = 4;
  localparam logic [23:0] FG  = 24'hBF40BF;
  localparam logic [23:0] BG  = 24'hFFD700;
  localparam logic [23:0] CLR = 24'hBF40BF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  x;
  logic [1:0]  y;
  logic        clear;
  logic [95:0] row_data;
  logic [2:0]  sel_v [2];

  logic [1:0]  addr_o [2];
  logic [7:0]  r_o [2];
  logic [7:0]  g_o [2];
  logic [7:0]  b_o [2];
  logic [2:0]  cur_o [2];
  logic        busy_o [2];
  logic        tick_o [2];

  logic [15:0] img_rows [6] = '{16'h0F0F, 16'h7FFE, 16'h00FF, 16'hAAAA, 16'h8001, 16'h5555};

  int tests = 0;
  int fails = 0;
  int fnum  = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  frame_compositor #(.WIDTH(W), .HEIGHT(H), .NUM_IMAGES(6), .DEFAULT_IMG(4), .WIPE_STEP(0)) dut_inst (
    .CLOCK_50(clk), .reset(reset), .x(x), .y(y), .sel(sel_v[0]), .clear(clear),
`ifdef BLINK_EN
    .blink(1'b0),
`endif
    .row_data(row_data), .rom_addr(addr_o[0]), .r(r_o[0]), .g(g_o[0]), .b(b_o[0]),
    .cur_img(cur_o[0]), .busy(busy_o[0]), .frame_tick(tick_o[0]));

  frame_compositor #(.WIDTH(W), .HEIGHT(H), .NUM_IMAGES(6), .DEFAULT_IMG(4), .WIPE_STEP(4)) dut_wipe (
    .CLOCK_50(clk), .reset(reset), .x(x), .y(y), .sel(sel_v[1]), .clear(clear),
`ifdef BLINK_EN
    .blink(1'b0),
`endif
    .row_data(row_data), .rom_addr(addr_o[1]), .r(r_o[1]), .g(g_o[1]), .b(b_o[1]),
    .cur_img(cur_o[1]), .busy(busy_o[1]), .frame_tick(tick_o[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rgb_of(input int m);
    return {8'h00, r_o[m], g_o[m], b_o[m]};
  endfunction

  // ---------------- frame-level reference model ----------------
  int          m_cur [2];
  int          m_old [2];
  int          m_k [2];
  bit          m_busy [2];
  logic [23:0] m_p1 [2];
  logic [23:0] m_out [2];
  bit          m_tick;
  bit          m_prev0;
  bit          fs_now;

  function automatic int sanitise(input logic [2:0] s);
    return (s >= 3'd6) ? 4 : int'(s);
  endfunction

  function automatic logic [23:0] colour(input int img, input int xx, input logic clr);
    logic [15:0] row;
    row = img_rows[img];
    if (clr) return CLR;
    return row[4'(15 - xx)] ? FG : BG;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_prev0 = 1'b0;
      m_tick  = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_cur[m] = 4; m_old[m] = 4; m_k[m] = 0; m_busy[m] = 1'b0;
        m_p1[m] = 24'h0; m_out[m] = 24'h0;
      end
    end else begin
      fs_now  = (x == 4'd0) && (y == 2'd0) && !m_prev0;
      m_prev0 = (x == 4'd0) && (y == 2'd0);
      m_tick  = fs_now;
      for (int m = 0; m < 2; m++) begin
        int s;
        int st;
        int img;
        st = (m == 0) ? 0 : 4;
        if (fs_now) begin
          if (!m_busy[m]) begin
            s = sanitise(sel_v[m]);
            if (s != m_cur[m]) begin
              if (st == 0) m_cur[m] = s;
              else begin
                m_old[m] = m_cur[m]; m_cur[m] = s; m_busy[m] = 1'b1; m_k[m] = 0;
              end
            end
          end else begin
            m_k[m]++;
            if (m_k[m] * st >= W) m_busy[m] = 1'b0;
          end
        end
        img = (m_busy[m] && int'(x) >= m_k[m] * st) ? m_old[m] : m_cur[m];
        m_out[m] = m_p1[m];
        m_p1[m]  = colour(img, int'(x), clear);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("dut%0d rgb", m), rgb_of(m), {8'h00, m_out[m]});
        check($sformatf("dut%0d cur_img", m), 32'(cur_o[m]), 32'(m_cur[m]));
        check($sformatf("dut%0d busy", m), 32'(busy_o[m]), 32'(m_busy[m]));
        check($sformatf("dut%0d frame_tick", m), 32'(tick_o[m]), 32'(m_tick));
        check($sformatf("dut%0d rom_addr", m), 32'(addr_o[m]), 32'(y));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive_hook(input int f, input int xx, input int yy);
    clear = 1'b0;
    case (f)
      1: if (xx == 5 && yy == 1) begin sel_v[0] = 3'd2; sel_v[1] = 3'd1; end
      2: if (xx == 8 && yy == 2) begin sel_v[0] = 3'd7; sel_v[1] = 3'd3; end
      4: if (xx == 8 && yy == 2) begin sel_v[0] = 3'd2; sel_v[1] = 3'd1; end
      6: if (xx == 2 && yy == 2) clear = 1'b1;
      7: if (xx == 8 && yy == 2) sel_v[1] = 3'd2;
      default: ;
    endcase
  endtask

  // After presenting pixel n, r/g/b show pixel n-1 while cur_img/busy/frame_tick reflect pixel n's edge.
  task automatic lit_hook(input int f, input int n);
    case (f)
      0: begin
        if (n == 0)  check("first frame_tick", 32'(tick_o[0]), 32'd1);
        if (n == 1)  check("tick one cycle", 32'(tick_o[0]), 32'd0);
        if (n == 1)  check("x0 colour", rgb_of(0), 32'h00BF40BF);
        if (n == 1)  check("x0 colour wipe dut", rgb_of(1), 32'h00BF40BF);
        if (n == 2)  check("x1 colour", rgb_of(0), 32'h00FFD700);
        if (n == 16) check("x15 colour", rgb_of(0), 32'h00BF40BF);
      end
      1: if (n == 63) begin
        check("mid-frame sel held inst", 32'(cur_o[0]), 32'd4);
        check("mid-frame sel held wipe", 32'(cur_o[1]), 32'd4);
        check("no busy before commit", 32'(busy_o[1]), 32'd0);
      end
      2: begin
        if (n == 0) begin
          check("inst commit", 32'(cur_o[0]), 32'd2);
          check("inst never busy", 32'(busy_o[0]), 32'd0);
          check("wipe commit", 32'(cur_o[1]), 32'd1);
          check("wipe busy", 32'(busy_o[1]), 32'd1);
        end
        if (n == 15) check("wipe frame0 old image", rgb_of(1), 32'h00FFD700);
      end
      3: begin
        if (n == 0) check("sel 7 sanitised", 32'(cur_o[0]), 32'd4);
        if (n == 4) check("wipe frame1 x3 new", rgb_of(1), 32'h00BF40BF);
        if (n == 5) check("wipe frame1 x4 old", rgb_of(1), 32'h00FFD700);
      end
      5: if (n == 63) check("busy before 4th tick", 32'(busy_o[1]), 32'd1);
      6: begin
        if (n == 0)  check("busy falls 4th tick", 32'(busy_o[1]), 32'd0);
        if (n == 34) check("pixel before clear", rgb_of(0), 32'h00FFD700);
        if (n == 35) check("clear pixel", rgb_of(0), 32'h00BF40BF);
        if (n == 36) check("pixel after clear", rgb_of(0), 32'h00FFD700);
      end
      7: if (n == 63) begin
        check("no second transition", 32'(busy_o[1]), 32'd0);
        check("ends on image 1", 32'(cur_o[1]), 32'd1);
      end
      9: begin
        if (n == 0) check("refill still zero", rgb_of(1), 32'h0);
        if (n == 1) check("first pixel after reset", rgb_of(1), 32'h00BF40BF);
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int npix);
    for (int n = 0; n < npix; n++) begin
      int xx;
      int yy;
      xx = n % W;
      yy = n / W;
      drive_hook(fnum, xx, yy);
      x = 4'(xx);
      y = 2'(yy);
      @(posedge clk);
      #1;
      lit_hook(fnum, n);
    end
    fnum++;
  endtask

  initial begin
    x = 4'd0; y = 2'd0; clear = 1'b0;
    sel_v[0] = 3'd4; sel_v[1] = 3'd4;
    for (int i = 0; i < 6; i++) row_data[i*16 +: 16] = img_rows[i];

    #1 reset = 1'b1;
    run_cmp = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("reset rgb", rgb_of(m), 32'h0);
      check("reset busy", 32'(busy_o[m]), 32'd0);
      check("reset cur_img", 32'(cur_o[m]), 32'd4);
      check("reset frame_tick", 32'(tick_o[m]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int f = 0; f < 8; f++) run_frame(64);

    run_frame(40);
    #2 reset = 1'b1;
    #1;
    check("async reset rgb inst", rgb_of(0), 32'h0);
    check("async reset rgb wipe", rgb_of(1), 32'h0);
    check("async reset busy", 32'(busy_o[1]), 32'd0);
    check("async reset cur_img", 32'(cur_o[1]), 32'd4);
    x = 4'd0; y = 2'd0; clear = 1'b0;
    sel_v[0] = 3'd4; sel_v[1] = 3'd4;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_frame(64);
    run_frame(64);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
